// File: rtl/reg_port_arbiter.sv
// reg_port_arbiter
// Shares the register-file select port between the CPU control sequencer and
// the debug/IO loader. One owner at a time, round-robin tie-break, bounded hold
// under contention, and a forced idle cycle between owners. The granted side's
// latched index is decoded 4->16 into one-hot Rin (write) or Rout (read) enables.
// All outputs are registered and computed from the next state, so a grant taken
// at an edge is visible with valid enables immediately after that edge.

module reg_port_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_idx,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [3:0]  dbg_idx,
    output logic        cpu_gnt,
    output logic        dbg_gnt,
    output logic [15:0] r_in,
    output logic [15:0] r_out,
    output logic        busy
);

    // Hold counter only needs to reach MAX_HOLD-1; keep at least one bit.
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_CPU = 2'd1,
        OWN_DBG = 2'd2
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          last_dbg;

    // Index 15 is reserved: the owner keeps the grant but no register is enabled.
    function automatic logic [15:0] decode(input logic [3:0] idx);
        logic [15:0] onehot;
        onehot = 16'h0;
        if (idx != 4'hF)
            onehot = 16'h1 << idx;
        return onehot;
    endfunction

    // Arbitration FSM with registered grant, busy and decoded enable outputs.
    // Enables are captured only on entry to an ownership state, so idx/we
    // changes during ownership have no effect until the requester re-requests.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= IDLE;
            hold_cnt <= '0;
            last_dbg <= 1'b1;
            cpu_gnt  <= 1'b0;
            dbg_gnt  <= 1'b0;
            busy     <= 1'b0;
            r_in     <= 16'h0;
            r_out    <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req && (!dbg_req || last_dbg)) begin
                        state    <= OWN_CPU;
                        hold_cnt <= '0;
                        last_dbg <= 1'b0;
                        cpu_gnt  <= 1'b1;
                        dbg_gnt  <= 1'b0;
                        busy     <= 1'b1;
                        r_in     <= cpu_we ? decode(cpu_idx) : 16'h0;
                        r_out    <= cpu_we ? 16'h0 : decode(cpu_idx);
                    end else if (dbg_req) begin
                        state    <= OWN_DBG;
                        hold_cnt <= '0;
                        last_dbg <= 1'b1;
                        cpu_gnt  <= 1'b0;
                        dbg_gnt  <= 1'b1;
                        busy     <= 1'b1;
                        r_in     <= dbg_we ? decode(dbg_idx) : 16'h0;
                        r_out    <= dbg_we ? 16'h0 : decode(dbg_idx);
                    end
                end

                OWN_CPU: begin
                    if (!cpu_req || (dbg_req && hold_cnt == HOLD_LAST)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        cpu_gnt  <= 1'b0;
                        dbg_gnt  <= 1'b0;
                        busy     <= 1'b0;
                        r_in     <= 16'h0;
                        r_out    <= 16'h0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                OWN_DBG: begin
                    if (!dbg_req || (cpu_req && hold_cnt == HOLD_LAST)) begin
                        state    <= IDLE;
                        hold_cnt <= '0;
                        cpu_gnt  <= 1'b0;
                        dbg_gnt  <= 1'b0;
                        busy     <= 1'b0;
                        r_in     <= 16'h0;
                        r_out    <= 16'h0;
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                    cpu_gnt  <= 1'b0;
                    dbg_gnt  <= 1'b0;
                    busy     <= 1'b0;
                    r_in     <= 16'h0;
                    r_out    <= 16'h0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// tb_reg_port_arbiter
// Directed bench for reg_port_arbiter (MAX_HOLD=4). Inputs change 1ns after a
// rising edge; outputs are sampled 1ns after the following rising edge.

module tb_reg_port_arbiter;

    logic        clk;
    logic        clr;
    logic        cpu_req;
    logic        cpu_we;
    logic [3:0]  cpu_idx;
    logic        dbg_req;
    logic        dbg_we;
    logic [3:0]  dbg_idx;
    logic        cpu_gnt;
    logic        dbg_gnt;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        busy;

    int checks;
    int errors;

    reg_port_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .clr     (clr),
        .cpu_req (cpu_req),
        .cpu_we  (cpu_we),
        .cpu_idx (cpu_idx),
        .dbg_req (dbg_req),
        .dbg_we  (dbg_we),
        .dbg_idx (dbg_idx),
        .cpu_gnt (cpu_gnt),
        .dbg_gnt (dbg_gnt),
        .r_in    (r_in),
        .r_out   (r_out),
        .busy    (busy)
    );

    // 10ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic apply_stimulus(input logic c_req, input logic c_we, input logic [3:0] c_idx,
                                  input logic d_req, input logic d_we, input logic [3:0] d_idx);
        cpu_req = c_req;
        cpu_we  = c_we;
        cpu_idx = c_idx;
        dbg_req = d_req;
        dbg_we  = d_we;
        dbg_idx = d_idx;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic e_cpu, input logic e_dbg,
                                input logic e_busy, input logic [15:0] e_rin,
                                input logic [15:0] e_rout);
        logic [34:0] observed;
        logic [34:0] expected;
        observed = {cpu_gnt, dbg_gnt, busy, r_in, r_out};
        expected = {e_cpu, e_dbg, e_busy, e_rin, e_rout};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed gnt c/d=%b%b busy=%b r_in=%h r_out=%h expected gnt c/d=%b%b busy=%b r_in=%h r_out=%h",
                   tag, observed[34], observed[33], observed[32], observed[31:16], observed[15:0],
                   e_cpu, e_dbg, e_busy, e_rin, e_rout);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clr = 1'b1;
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        check_output("reset_state", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        check_output("reset_held_over_edge", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        clr = 1'b0;

        // No requests: stays idle
        tick();
        check_output("idle_no_req", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // CPU read of R5 alone, then release
        apply_stimulus(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 4'h0);
        tick();
        check_output("cpu_read_r5", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0020);
        apply_stimulus(1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 4'h0);
        tick();
        check_output("cpu_release", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Fresh reset, then simultaneous requests: CPU wins the first tie
        clr = 1'b1;
        #1;
        clr = 1'b0;
        apply_stimulus(1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 4'd3);
        tick();
        check_output("tie_cpu_first", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002);
        apply_stimulus(1'b0, 1'b0, 4'd1, 1'b1, 1'b1, 4'd3);
        tick();
        check_output("dead_cycle", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        check_output("dbg_write_r3", 1'b0, 1'b1, 1'b1, 16'h0008, 16'h0000);
        apply_stimulus(1'b0, 1'b0, 4'd1, 1'b0, 1'b1, 4'd3);
        tick();
        check_output("dbg_release", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Contention: last served was DBG, so CPU first; each side holds 4 cycles
        apply_stimulus(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("contend_cpu_hold", 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000);
        end
        tick();
        check_output("contend_gap1", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("contend_dbg_hold", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0080);
        end
        tick();
        check_output("contend_gap2", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        check_output("contend_cpu_regrant", 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000);
        apply_stimulus(1'b0, 1'b1, 4'd2, 1'b0, 1'b0, 4'd7);
        tick();
        check_output("contend_release", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reserved index 15: granted and busy but no enables
        apply_stimulus(1'b1, 1'b1, 4'd15, 1'b0, 1'b0, 4'h0);
        tick();
        check_output("idx15_write", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000);
        apply_stimulus(1'b0, 1'b1, 4'd15, 1'b0, 1'b0, 4'h0);
        tick();
        check_output("idx15_release", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Uncontended owner keeps the port beyond the hold limit
        apply_stimulus(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check_output("uncontended_long_hold", 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0000);
        apply_stimulus(1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'h0);
        tick();
        check_output("uncontended_release", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Reset mid-grant while DBG owns and both are requesting
        apply_stimulus(1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 4'd9);
        tick();
        check_output("dbg_read_r9", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200);
        apply_stimulus(1'b1, 1'b0, 4'd4, 1'b1, 1'b0, 4'd9);
        tick();
        check_output("dbg_holds_vs_cpu", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0200);
        #2;
        clr = 1'b1;
        #1;
        check_output("clr_async_midgrant", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        check_output("clr_held_midgrant", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #2;
        clr = 1'b0;
        tick();
        check_output("post_clr_cpu_wins", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010);
        apply_stimulus(1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 4'd9);
        tick();
        check_output("idx_change_ignored", 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
